seven_seg_scan_reader: RTL and testbench

Monitors the multiplexed, active-low anode and segment lines of a seven-segment display and reconstructs the displayed hex digits and decimal points. It is the receive-side counterpart of the hex/BCD segment decoder and the scan driver. It sits on display pins, either looped back or in a test harness. It debounces each scan dwell, maps each segment pattern back to a nibble, flags illegal patterns and multiple-anode faults, and pulses once per complete scan frame.

---
 rtl/seven_seg_scan_reader.sv | 136 +++++++++++++
 tb/tb_seven_seg_scan_reader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_reader.sv
// Receive-side seven-segment monitor: debounces each scan dwell, decodes the
// active-low segment pattern back to a nibble and reports frame completion.
module seven_seg_scan_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     anodes,
    input  logic [7:0]            segments,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic [DIGITS-1:0]     dps_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  frame_done,
    output logic                  error
);
    localparam int             CW   = $clog2(STABLE_CYCLES + 1);
    localparam int             IW   = DIGITS + 8;
    localparam logic [CW-1:0]  CMAX = CW'(STABLE_CYCLES);

    logic [IW-1:0]          in_q, in_d, sample;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   captured_q, captured_d;
    logic [DIGITS-1:0]      mask_q, mask_d;
    logic [4*DIGITS-1:0]    digits_q, digits_d;
    logic [DIGITS-1:0]      dps_q, dps_d;
    logic [DIGITS-1:0]      valid_q, valid_d;
    logic                   frame_q, frame_d;
    logic                   err_q, err_d;

    logic                   accept, one_low, multi_low;
    logic [DIGITS-1:0]      sel;
    logic [4:0]             dec;

    // Returns {match, nibble} for an active-high abc_defg pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        case (p)
            7'h7E:   seg_decode = {1'b1, 4'h0};
            7'h30:   seg_decode = {1'b1, 4'h1};
            7'h6D:   seg_decode = {1'b1, 4'h2};
            7'h79:   seg_decode = {1'b1, 4'h3};
            7'h33:   seg_decode = {1'b1, 4'h4};
            7'h5B:   seg_decode = {1'b1, 4'h5};
            7'h5F:   seg_decode = {1'b1, 4'h6};
            7'h70:   seg_decode = {1'b1, 4'h7};
            7'h7F:   seg_decode = {1'b1, 4'h8};
            7'h7B:   seg_decode = {1'b1, 4'h9};
            7'h77:   seg_decode = {1'b1, 4'hA};
            7'h1F:   seg_decode = {1'b1, 4'hB};
            7'h0D:   seg_decode = {1'b1, 4'hC};
            7'h3D:   seg_decode = {1'b1, 4'hD};
            7'h4F:   seg_decode = {1'b1, 4'hE};
            7'h47:   seg_decode = {1'b1, 4'hF};
            default: seg_decode = 5'b0_0000;
        endcase
    endfunction

    assign sample    = {anodes, segments};
    assign sel       = ~in_q[IW-1:8];
    assign multi_low = (sel & (sel - DIGITS'(1))) != '0;
    assign one_low   = (sel != '0) && !multi_low;
    assign accept    = (cnt_q == CMAX) && !captured_q;
    assign dec       = seg_decode(~in_q[6:0]);

    always_comb begin
        in_d       = sample;
        cnt_d      = cnt_q;
        captured_d = captured_q;
        mask_d     = mask_q;
        digits_d   = digits_q;
        dps_d      = dps_q;
        valid_d    = valid_q;
        frame_d    = 1'b0;
        err_d      = 1'b0;

        if (accept) begin
            captured_d = 1'b1;
            if (one_low) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel[i]) begin
                        dps_d[i]   = ~in_q[7];
                        valid_d[i] = dec[4];
                        if (dec[4]) digits_d[4*i +: 4] = dec[3:0];
                    end
                end
                err_d = ~dec[4];
                if ((mask_q | sel) == '1) begin
                    frame_d = 1'b1;
                    mask_d  = '0;
                end else begin
                    mask_d = mask_q | sel;
                end
            end else if (multi_low) begin
                err_d = 1'b1;
            end
        end

        // A changed sample starts a fresh dwell even on an accept edge.
        if (sample != in_q) begin
            cnt_d      = CW'(1);
            captured_d = 1'b0;
        end else if (cnt_q != CMAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q       <= '1;
            cnt_q      <= '0;
            captured_q <= 1'b0;
            mask_q     <= '0;
            digits_q   <= '0;
            dps_q      <= '0;
            valid_q    <= '0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            in_q       <= in_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            mask_q     <= mask_d;
            digits_q   <= digits_d;
            dps_q      <= dps_d;
            valid_q    <= valid_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
        end
    end

    assign digits_out  = digits_q;
    assign dps_out     = dps_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_q;
    assign error       = err_q;
endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// Scoreboard bench: stimulus pushes hand-computed output events with their
// expected edge; a negedge monitor pops one per observed output event.
module tb_seven_seg_scan_reader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  anodes;
    logic [7:0]  segments;
    logic [15:0] digits_out;
    logic [3:0]  dps_out;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        error;

    seven_seg_scan_reader #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .anodes      (anodes),
        .segments    (segments),
        .digits_out  (digits_out),
        .dps_out     (dps_out),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .error       (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [15:0] dig;
        logic [3:0]  dps;
        logic [3:0]  vld;
        logic        fd;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;
    logic [15:0] p_dig;
    logic [3:0]  p_dps, p_vld;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [15:0] d, input logic [3:0] dp,
                        input logic [3:0] v, input logic fd, input logic er);
        exp_t e;
        e.cyc = c; e.dig = d; e.dps = dp; e.vld = v; e.fd = fd; e.err = er;
        q.push_back(e);
    endtask

    // Drive at posedge+1 so the value is first sampled at the next edge.
    task automatic hold(input logic [3:0] an, input logic [7:0] sg, input int n);
        anodes = an; segments = sg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && (digits_out !== p_dig || dps_out !== p_dps ||
                       digit_valid !== p_vld || frame_done === 1'b1 || error === 1'b1)) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_event: cyc %0d dig %h dps %b vld %b fd %b err %b",
                         cyc, digits_out, dps_out, digit_valid, frame_done, error);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("evt_cycle",  cyc,         e.cyc);
                chk("digits_out", digits_out,  e.dig);
                chk("dps_out",    dps_out,     e.dps);
                chk("digit_valid",digit_valid, e.vld);
                chk("frame_done", frame_done,  e.fd);
                chk("error",      error,       e.err);
            end
        end
        p_dig = digits_out;
        p_dps = dps_out;
        p_vld = digit_valid;
    end

    initial begin
        int t0;
        // Reset with random pins
        rst_n = 1'b0;
        anodes = 4'($urandom); segments = 8'($urandom);
        @(negedge clk);
        chk("rst_digits", digits_out,  16'h0);
        chk("rst_dps",    dps_out,     4'h0);
        chk("rst_valid",  digit_valid, 4'h0);
        chk("rst_fd",     frame_done,  1'b0);
        chk("rst_err",    error,       1'b0);
        repeat (2) begin
            anodes = 4'($urandom); segments = 8'($urandom);
            @(posedge clk);
        end
        #1;
        mon_en = 1;
        rst_n  = 1'b1;
        hold(4'hF, 8'hFF, 20);

        // Single digit 2 on digit 0, then a long hold
        t0 = cyc;
        push(t0 + 5, 16'h0002, 4'b0000, 4'b0001, 0, 0);
        hold(4'b1110, 8'h92, 54);

        // Glitch: digit 0 -> value 0, interrupted after 3 cycles
        t0 = cyc;
        push(t0 + 9, 16'h0000, 4'b0000, 4'b0001, 0, 0);
        hold(4'b1110, 8'h81, 3);
        hold(4'b1110, 8'h80, 1);
        hold(4'b1110, 8'h81, 8);

        // Full frame A,5.,F,1 twice
        t0 = cyc;
        push(t0 + 5,  16'h000A, 4'b0000, 4'b0001, 0, 0);
        push(t0 + 11, 16'h005A, 4'b0010, 4'b0011, 0, 0);
        push(t0 + 17, 16'h0F5A, 4'b0010, 4'b0111, 0, 0);
        push(t0 + 23, 16'h1F5A, 4'b0010, 4'b1111, 1, 0);
        push(t0 + 47, 16'h1F5A, 4'b0010, 4'b1111, 1, 0);
        repeat (2) begin
            hold(4'b1110, 8'h88, 6);
            hold(4'b1101, 8'h24, 6);
            hold(4'b1011, 8'hB8, 6);
            hold(4'b0111, 8'hCF, 6);
        end

        // Illegal pattern on digit 2 with dp on
        t0 = cyc;
        push(t0 + 5, 16'h1F5A, 4'b0110, 4'b1011, 0, 1);
        hold(4'b1011, 8'h7E, 10);

        // Two anodes low: one error, nothing else
        t0 = cyc;
        push(t0 + 5, 16'h1F5A, 4'b0110, 4'b1011, 0, 1);
        hold(4'b1100, 8'h88, 10);

        // Digit 3 = 2: mask is {2,3} only, so no frame pulse
        t0 = cyc;
        push(t0 + 5, 16'h2F5A, 4'b0110, 4'b1011, 0, 0);
        hold(4'b0111, 8'h92, 8);

        // Reset mid-dwell on digit 0: dwell discarded
        t0 = cyc;
        hold(4'b1110, 8'h81, 2);
        rst_n = 1'b0;
        push(t0 + 3, 16'h0000, 4'b0000, 4'b0000, 0, 0);
        hold(4'b1110, 8'h81, 1);
        rst_n = 1'b1;
        hold(4'hF, 8'hFF, 20);

        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
